keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//   Input-side companion of the board I/O interface: scans a 4x4 matrix keypad, debounces
//   presses and releases, and presents a 4-bit key code with a valid/ack handshake for the
//   CPU I/O read path (key code feeds the I/O interface's keyboard value input).
//   One key event per physical press; auto-repeat is not supported.
// PARAMETERS
//   SCAN_DIV     1000    clocks each column is driven before advancing (>=2)
//   DEBOUNCE_CNT 20000   consecutive stable clocks required to accept a press or release (>=2)
// PORTS
//   clk_i           in   1  system clock; all logic on posedge
//   reset_i         in   1  synchronous active-high reset
//   row_i[3:0]      in   4  keypad rows, pulled up; 0 = key in driven column closed
//   col_o[3:0]      out  4  column drive, active-low, exactly one bit low at all times
//   key_val_o[3:0]  out  4  code of last accepted key = {row_idx[1:0], col_idx[1:0]}
//   key_valid_o     out  1  high from acceptance until key_ack_i
//   key_ack_i       in   1  consumer ack; one-cycle pulse clears key_valid_o
//   key_down_o      out  1  high while a debounced key is held (DEBOUNCE/HOLD exit rules below)
//   overrun_o       out  1  sticky: key accepted while key_valid_o already high
// BEHAVIOUR
//   Reset (cycle after reset_i sampled high, and while held): state=SCAN, col_idx=0,
//     col_o=4'b1110, dwell/debounce counters=0, key_val_o=0, key_valid_o=0, key_down_o=0,
//     overrun_o=0. Reset mid-press discards the press; a still-held key is re-debounced from SCAN.
//   row_i passes through a 2-flop synchronizer; "rows" below means the synchronized value
//     (2-cycle input latency).
//   SCAN: dwell counter counts 0..SCAN_DIV-1 per column; on count SCAN_DIV-1 sample rows.
//     rows==4'hF: col_idx <= col_idx+1 (3 wraps to 0), dwell <= 0.
//     rows!=4'hF: capture col_idx and row pattern, -> DEBOUNCE, column frozen, deb cnt <= 0.
//   DEBOUNCE: each cycle rows==captured pattern -> cnt+1; any mismatch -> SCAN (column kept,
//     dwell <= 0), no event. When cnt reaches DEBOUNCE_CNT-1 with match: accept, -> HOLD.
//   Accept (single cycle): key_val_o <= {lowest row idx with 0 in pattern, col_idx};
//     key_valid_o <= 1; key_down_o <= 1; if key_valid_o already 1 and no key_ack_i that
//     cycle -> overrun_o <= 1 (key_val_o still overwritten with newest code).
//   HOLD: column frozen; deb cnt counts consecutive cycles rows==4'hF, any low row resets it to 0.
//     At DEBOUNCE_CNT-1: key_down_o <= 0, -> SCAN starting at col_idx+1, dwell <= 0.
//     Other keys pressed during HOLD are ignored (no second event, no overrun).
//   Multiple rows low in one column: lowest row index wins. Keys in other columns are not
//     seen until the held key is released.
//   Handshake: key_ack_i with key_valid_o=1 -> key_valid_o <= 0 and overrun_o <= 0 next cycle.
//     Ack with key_valid_o=0 has no effect. Ack in same cycle as accept: accept wins,
//     key_valid_o stays 1, overrun_o not set, overrun_o cleared.
//   key_val_o holds its value after ack until the next accept.
//   Counters sized $clog2 of their parameter; no overflow: every counter is reset on state change.
//   Press-to-valid latency from stable row edge: 2 (sync) + up to 4*SCAN_DIV (scan)
//     + DEBOUNCE_CNT cycles.
// TESTING (bench params SCAN_DIV=4, DEBOUNCE_CNT=8)
//   Reset -> col_o=1110, rotates 1110,1101,1011,0111,1110 every 4 clocks; all outputs 0.
//   Hold row2/col1 closed (row_i=1011 when col_o=1101) -> key_valid_o=1, key_val_o=4'h9,
//     key_down_o=1; ack pulse -> key_valid_o=0 next cycle, key_val_o stays 9.
//   Bounce: row pattern toggles every 3 clocks for 30 clocks, then stable -> exactly one event;
//     glitch shorter than 8 clocks alone -> no event, scan resumes.
//   Press/release key 0 then key 15 with no ack -> key_val_o=4'hF, overrun_o=1; ack -> both flags 0.
//   Row0+row3 low in col2 -> key_val_o=4'h2; release held 5 clocks then re-closed -> no new event.
//   reset_i for 1 cycle during DEBOUNCE and during HOLD -> outputs 0, col_o=1110, key re-detected once.

Source files
------------

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 matrix keypad one column at a time and debounces
// both the press and the release of a key. Each physical press produces one
// 4-bit key code {row, column}, held behind a valid/ack handshake for the CPU.
module keypad_scanner #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 20000
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [3:0] row_i,
    output logic [3:0] col_o,
    output logic [3:0] key_val_o,
    output logic       key_valid_o,
    input  logic       key_ack_i,
    output logic       key_down_o,
    output logic       overrun_o
);

    localparam int DWELL_W = $clog2(SCAN_DIV);
    localparam int DEB_W   = $clog2(DEBOUNCE_CNT);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE_CNT - 1);

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_HOLD
    } scanState_t;

    // Synchronizer for the asynchronous row lines.
    logic [3:0]         r_rowMeta;
    logic [3:0]         r_rowSync;

    // Scanner state.
    scanState_t         r_state;
    logic [1:0]         r_colIdx;
    logic [DWELL_W-1:0] r_dwell;
    logic [DEB_W-1:0]   r_deb;
    logic [3:0]         r_pattern;

    // Handshake outputs.
    logic [3:0]         r_keyVal;
    logic               r_keyValid;
    logic               r_keyDown;
    logic               r_overrun;

    // Next-state values from the FSM.
    scanState_t         w_stateNext;
    logic [1:0]         w_colIdxNext;
    logic [DWELL_W-1:0] w_dwellNext;
    logic [DEB_W-1:0]   w_debNext;
    logic [3:0]         w_patternNext;
    logic               w_accept;
    logic               w_release;
    logic [1:0]         w_lowRow;

    // Two flops settle the row lines before the FSM looks at them; reset parks
    // them at "no key" so a still-held key is detected fresh afterwards.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_rowMeta <= 4'hF;
            r_rowSync <= 4'hF;
        end else begin
            r_rowMeta <= row_i;
            r_rowSync <= r_rowMeta;
        end
    end

    // Next-state logic: dwell on each column, chase a candidate pattern through
    // the debounce window, then sit in HOLD until the keypad has been quiet long
    // enough. Every counter restarts on a state change so none can overflow.
    always_comb begin
        w_stateNext   = r_state;
        w_colIdxNext  = r_colIdx;
        w_dwellNext   = r_dwell;
        w_debNext     = r_deb;
        w_patternNext = r_pattern;
        w_accept      = 1'b0;
        w_release     = 1'b0;
        case (r_state)
            ST_SCAN: begin
                if (r_dwell == DWELL_LAST) begin
                    w_dwellNext = '0;
                    if (r_rowSync == 4'hF) begin
                        w_colIdxNext = r_colIdx + 2'd1;
                    end else begin
                        w_patternNext = r_rowSync;
                        w_debNext     = '0;
                        w_stateNext   = ST_DEBOUNCE;
                    end
                end else begin
                    w_dwellNext = r_dwell + 1'b1;
                end
            end
            ST_DEBOUNCE: begin
                if (r_rowSync == r_pattern) begin
                    if (r_deb == DEB_LAST) begin
                        w_accept    = 1'b1;
                        w_debNext   = '0;
                        w_stateNext = ST_HOLD;
                    end else begin
                        w_debNext = r_deb + 1'b1;
                    end
                end else begin
                    w_dwellNext = '0;
                    w_debNext   = '0;
                    w_stateNext = ST_SCAN;
                end
            end
            ST_HOLD: begin
                if (r_rowSync == 4'hF) begin
                    if (r_deb == DEB_LAST) begin
                        w_release    = 1'b1;
                        w_debNext    = '0;
                        w_dwellNext  = '0;
                        w_colIdxNext = r_colIdx + 2'd1;
                        w_stateNext  = ST_SCAN;
                    end else begin
                        w_debNext = r_deb + 1'b1;
                    end
                end else begin
                    w_debNext = '0;
                end
            end
            default: begin
                w_dwellNext = '0;
                w_debNext   = '0;
                w_stateNext = ST_SCAN;
            end
        endcase
    end

    // The lowest-numbered closed row wins when several rows in one column are low.
    always_comb begin
        w_lowRow = 2'd3;
        if (!r_pattern[0]) begin
            w_lowRow = 2'd0;
        end else if (!r_pattern[1]) begin
            w_lowRow = 2'd1;
        end else if (!r_pattern[2]) begin
            w_lowRow = 2'd2;
        end
    end

    // State register for the scanner FSM and its counters.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state   <= ST_SCAN;
            r_colIdx  <= 2'd0;
            r_dwell   <= '0;
            r_deb     <= '0;
            r_pattern <= 4'hF;
        end else begin
            r_state   <= w_stateNext;
            r_colIdx  <= w_colIdxNext;
            r_dwell   <= w_dwellNext;
            r_deb     <= w_debNext;
            r_pattern <= w_patternNext;
        end
    end

    // Handshake: an accept always wins over an ack in the same cycle. Overrun
    // flags a new key landing on an unread one, and the newest code is kept.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_keyVal   <= 4'h0;
            r_keyValid <= 1'b0;
            r_keyDown  <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_keyVal   <= {w_lowRow, r_colIdx};
                r_keyValid <= 1'b1;
                r_overrun  <= r_keyValid && !key_ack_i;
            end else if (key_ack_i && r_keyValid) begin
                r_keyValid <= 1'b0;
                r_overrun  <= 1'b0;
            end
            if (w_accept) begin
                r_keyDown <= 1'b1;
            end else if (w_release) begin
                r_keyDown <= 1'b0;
            end
        end
    end

    assign col_o       = ~(4'b0001 << r_colIdx);
    assign key_val_o   = r_keyVal;
    assign key_valid_o = r_keyValid;
    assign key_down_o  = r_keyDown;
    assign overrun_o   = r_overrun;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: drives a modelled key matrix into keypad_scanner and
// checks key events against an event-level model (one event per long press,
// none for short glitches, overrun when an unread key is overwritten).
module tb_keypad_scanner;

    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE_CNT = 8;
    localparam int PRESS_WAIT   = 45;
    localparam int RELEASE_WAIT = 20;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] rowIn;
    logic [3:0] colOut;
    logic [3:0] keyVal;
    logic       keyValid;
    logic       keyAck;
    logic       keyDown;
    logic       overrun;

    logic [15:0] keysPressed;

    int   vectorCount = 0;
    int   missCount   = 0;
    int   acceptCount = 0;
    logic prevDown    = 1'b0;

    logic       expValid;
    logic [3:0] expVal;
    logic       expOverrun;
    int         expAccepts;

    keypad_scanner #(
        .SCAN_DIV    (SCAN_DIV),
        .DEBOUNCE_CNT(DEBOUNCE_CNT)
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .row_i      (rowIn),
        .col_o      (colOut),
        .key_val_o  (keyVal),
        .key_valid_o(keyValid),
        .key_ack_i  (keyAck),
        .key_down_o (keyDown),
        .overrun_o  (overrun)
    );

    always #5 clk = ~clk;

    // Key matrix: a row is pulled low when any pressed key on it sits in the
    // column currently driven low.
    always_comb begin
        rowIn = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keysPressed[r*4+c] && !colOut[c]) begin
                    rowIn[r] = 1'b0;
                end
            end
        end
    end

    // Count observed key events as rising edges of key_down.
    always @(negedge clk) begin
        if (keyDown === 1'b1 && prevDown !== 1'b1) begin
            acceptCount++;
        end
        prevDown = keyDown;
    end

    // Give up if the stimulus ever stalls.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [15:0] keys, input int cycles);
        keysPressed = keys;
        tick(cycles);
    endtask

    function automatic logic [15:0] keyMask(input int k);
        logic [15:0] m;
        m = 16'h0001 << k;
        return m;
    endfunction

    task automatic modelPress(input int k);
        expAccepts++;
        if (expValid) expOverrun = 1'b1;
        expValid = 1'b1;
        expVal   = 4'(k);
    endtask

    task automatic pulseAck;
        keyAck = 1'b1;
        tick(1);
        keyAck = 1'b0;
        tick(1);
        if (expValid) begin
            expValid   = 1'b0;
            expOverrun = 1'b0;
        end
    endtask

    task automatic checkAll(input string tag, input logic expDown);
        checkOutput({tag, ".valid"},   32'(keyValid),  32'(expValid));
        checkOutput({tag, ".val"},     32'(keyVal),    32'(expVal));
        checkOutput({tag, ".down"},    32'(keyDown),   32'(expDown));
        checkOutput({tag, ".overrun"}, 32'(overrun),   32'(expOverrun));
        checkOutput({tag, ".events"},  32'(acceptCount), 32'(expAccepts));
        checkOutput({tag, ".colOneLow"}, 32'($countones(~colOut)), 32'd1);
    endtask

    task automatic resetDut(input string tag);
        keyAck = 1'b0;
        reset  = 1'b1;
        tick(1);
        reset      = 1'b0;
        expValid   = 1'b0;
        expVal     = 4'h0;
        expOverrun = 1'b0;
        checkOutput({tag, ".col"}, 32'(colOut), 32'hE);
        checkAll(tag, 1'b0);
    endtask

    task automatic waitForColumn(input int c);
        int budget;
        budget = 0;
        while (colOut[c] !== 1'b0 && budget < 100) begin
            tick(1);
            budget++;
        end
        checkOutput("waitColumn", 32'(colOut[c]), 32'd0);
    endtask

    task automatic glitch(input int k, input int len);
        waitForColumn(k % 4);
        applyStimulus(keyMask(k), len);
        applyStimulus(16'h0, RELEASE_WAIT);
    endtask

    initial begin
        logic [3:0] expCol;
        int k;
        int kind;

        keysPressed = 16'h0;
        keyAck      = 1'b0;
        reset       = 1'b1;
        expAccepts  = 0;
        expValid    = 1'b0;
        expVal      = 4'h0;
        expOverrun  = 1'b0;

        // Reset state and idle column rotation.
        resetDut("reset");
        for (int n = 0; n < 17; n++) begin
            expCol = 4'hF;
            expCol[(n / SCAN_DIV) % 4] = 1'b0;
            checkOutput("colRotate", 32'(colOut), 32'(expCol));
            tick(1);
        end

        // Single key: row2/col1, then ack.
        applyStimulus(keyMask(9), PRESS_WAIT);
        modelPress(9);
        checkAll("press9", 1'b1);
        pulseAck();
        checkAll("ack9", 1'b1);
        applyStimulus(16'h0, RELEASE_WAIT);
        checkAll("release9", 1'b0);

        // Bouncing contact settles into exactly one event.
        for (int i = 0; i < 10; i++) begin
            applyStimulus((i % 2 == 0) ? keyMask(6) : 16'h0, 3);
        end
        applyStimulus(keyMask(6), PRESS_WAIT);
        modelPress(6);
        checkAll("bounce", 1'b1);
        applyStimulus(16'h0, RELEASE_WAIT);
        pulseAck();
        checkAll("bounceAck", 1'b0);

        // Short glitch on a driven column produces nothing.
        glitch(15, 5);
        checkAll("glitch", 1'b0);

        // Two keys without ack: newest code kept, overrun raised.
        applyStimulus(keyMask(0), PRESS_WAIT);
        modelPress(0);
        applyStimulus(16'h0, RELEASE_WAIT);
        applyStimulus(keyMask(15), PRESS_WAIT);
        modelPress(15);
        applyStimulus(16'h0, RELEASE_WAIT);
        checkAll("overrun", 1'b0);
        pulseAck();
        checkAll("overrunAck", 1'b0);

        // Row0 and row3 in column 2; brief release does not re-trigger.
        applyStimulus(keyMask(2) | keyMask(14), PRESS_WAIT);
        modelPress(2);
        checkAll("multiRow", 1'b1);
        applyStimulus(16'h0, 5);
        applyStimulus(keyMask(2) | keyMask(14), 30);
        checkAll("shortRelease", 1'b1);
        applyStimulus(16'h0, RELEASE_WAIT);
        pulseAck();
        checkAll("multiRowRel", 1'b0);

        // A key in another column is ignored until the held key lets go.
        applyStimulus(keyMask(5), PRESS_WAIT);
        modelPress(5);
        applyStimulus(keyMask(5) | keyMask(10), PRESS_WAIT);
        checkAll("otherColHeld", 1'b1);
        applyStimulus(keyMask(10), 60);
        modelPress(10);
        checkAll("otherColNext", 1'b1);
        applyStimulus(16'h0, RELEASE_WAIT);
        pulseAck();
        checkAll("otherColAck", 1'b0);

        // Reset during debounce, then during hold; key is re-detected each time.
        keysPressed = keyMask(9);
        resetDut("preDeb");
        tick(11);
        resetDut("rstDebounce");
        tick(PRESS_WAIT);
        modelPress(9);
        checkAll("redetect1", 1'b1);
        resetDut("rstHold");
        tick(PRESS_WAIT);
        modelPress(9);
        checkAll("redetect2", 1'b1);
        applyStimulus(16'h0, RELEASE_WAIT);
        pulseAck();
        checkAll("rstDone", 1'b0);

        // Random presses, glitches and acks against the event model.
        for (int it = 0; it < 25; it++) begin
            k    = int'($urandom_range(0, 15));
            kind = int'($urandom_range(0, 3));
            if (kind == 0) begin
                glitch(k, int'($urandom_range(1, 6)));
                checkAll("rndGlitch", 1'b0);
            end else begin
                applyStimulus(keyMask(k), PRESS_WAIT);
                modelPress(k);
                checkAll("rndPress", 1'b1);
                if ($urandom_range(0, 1) == 1) begin
                    pulseAck();
                    checkAll("rndAckHeld", 1'b1);
                end
                applyStimulus(16'h0, RELEASE_WAIT);
                checkAll("rndRelease", 1'b0);
            end
            if ($urandom_range(0, 2) == 0) begin
                pulseAck();
                checkAll("rndAck", 1'b0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
